instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have these ports: clk  in  1  rising-edge clock.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 in_valid  in  1 / in_ready  out  1  input handshake.
REQ-004 in_kind  in  3  0=lw, 1=sw, 2=R-type, 3=beq, 4=I-type ALU, 5=jal, 6-7 illegal.
REQ-005 in_rd, in_rs1, in_rs2  in  5 each  register fields.
REQ-006 in_funct3  in  3 (R/I-type only) / in_funct7b5  in  1 (R-type only).
REQ-007 in_imm  in  32  signed byte-offset immediate.
REQ-008 out_valid  out  1 / out_ready  in  1  output handshake.
REQ-009 out_instr  out  32 / out_addr  out  32  encoded word and its byte address.
REQ-010 err_illegal  out  1 / err_range  out  1  sticky error flags.

Function
REQ-011 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-012 Encoding SHALL be RV32I: lw = imm[11:0],rs1,010,rd,0000011; sw = imm[11:5],rs2,rs1,010,imm[4:0],0100011.
REQ-013 R-type SHALL be {0,funct7b5,00000},rs2,rs1,funct3,rd,0110011; I-type ALU SHALL be imm[11:0],rs1,funct3,rd,0010011.
REQ-014 beq SHALL be imm[12],imm[10:5],rs2,rs1,000,imm[4:1],imm[11],1100011; jal SHALL be imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111.
REQ-015 Fields unused by a kind SHALL be ignored; in_imm SHALL be truncated to the kind's field bits.
REQ-016 Encoded words SHALL be buffered in a 2-entry FIFO; in_ready SHALL equal NOT full.
REQ-017 A word accepted at cycle N SHALL be presented with out_valid=1 at cycle N+1 at the earliest; there SHALL be no combinational path from in_* to out_*.
REQ-018 Push and pop in the same cycle SHALL be supported when the FIFO holds exactly 1 entry; occupancy stays 1.
REQ-019 out_instr SHALL hold the head entry and SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 out_addr SHALL start at 0 and SHALL increment by 4 on each output transfer, wrapping modulo 2^32.
REQ-021 An illegal kind SHALL be accepted (in_ready rules apply), SHALL NOT be pushed, and SHALL set err_illegal; out_addr SHALL be unchanged.
REQ-022 Output order SHALL equal acceptance order of legal inputs.

Reset
REQ-023 While reset=1 at a clk edge, the FIFO SHALL empty, out_valid=0, in_ready=1, out_addr=0, err_illegal=0, err_range=0; out_instr is don't-care while out_valid=0.
REQ-024 Reset mid-operation SHALL discard buffered words without emitting them.

Configuration
REQ-025 With ENC_RANGE_CHECK_EN defined, err_range SHALL be set on acceptance of an immediate outside these limits: signed 12-bit (lw/sw/I), signed 13-bit with bit0=0 (beq), signed 21-bit with bit0=0 (jal); the truncated word is still emitted.
REQ-026 Without ENC_RANGE_CHECK_EN, err_range SHALL be constant 0 and no check logic SHALL be present.

Structure
REQ-027 Package riscv_pkg SHALL hold the instr_kind_t enum and 7-bit opcode constants (LW, SW, RTYPE, BEQ, ITYPE, JAL), shared with the main decoder.
REQ-028 The FIFO SHALL be sub-module enc_fifo (2 entries, parameterised width); encoding logic SHALL be combinational ahead of the push.

Verification
REQ-029 Reset: after reset, out_valid=0, in_ready=1, out_addr=0, both error flags 0.
REQ-030 lw rd=6, rs1=9, imm=-4 -> next cycle out_instr=0xFFC4A303, out_addr=0; sw rs2=6, rs1=9, imm=8 -> 0x0064A423, addr 4.
REQ-031 out_ready=0; push add(rd5,rs1 6,rs2 7), beq(rs1 4,rs2 4,imm 8), jal(rd1,imm 16) -> in_ready=0 after two accepts; raise out_ready -> 0x007302B3@0, 0x00420463@4, 0x010000EF@8.
REQ-032 in_kind=7 with in_valid=1 -> accepted, no output, err_illegal=1 until reset, out_addr unchanged.
REQ-033 With ENC_RANGE_CHECK_EN: beq imm=4096 -> err_range=1; fresh reset, jal imm=5 -> err_range=1; lw imm=2047 -> err_range stays 0.
REQ-034 Two words buffered, reset asserted one cycle -> out_valid=0, out_addr=0, no buffered word ever emitted.

Source files
------------

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Brief    : Instruction kinds and RV32I opcodes shared by encoder and decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    typedef enum logic [2:0] {
        KIND_LW    = 3'd0,
        KIND_SW    = 3'd1,
        KIND_RTYPE = 3'd2,
        KIND_BEQ   = 3'd3,
        KIND_ITYPE = 3'd4,
        KIND_JAL   = 3'd5,
        KIND_ILL6  = 3'd6,
        KIND_ILL7  = 3'd7
    } instr_kind_t;

    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] RTYPE = 7'b0110011;
    localparam logic [6:0] BEQ   = 7'b1100011;
    localparam logic [6:0] ITYPE = 7'b0010011;
    localparam logic [6:0] JAL   = 7'b1101111;

    localparam logic [2:0] c_FUNCT3_WORD = 3'b010;
    localparam logic [2:0] c_FUNCT3_BEQ  = 3'b000;

endpackage

`default_nettype wire

// File: rtl/enc_fifo.sv
// ============================================================================
// Module   : enc_fifo
// Brief    : Two-entry FIFO with registered head; push and pop may coincide.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module enc_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Brief    : Encodes RV32I instruction descriptions into words, buffers them
//            and tags each emitted word with its byte address.
// Options  : ENC_RANGE_CHECK_EN - flag immediates that do not fit their field
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_kind,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7b5,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_illegal,
    output logic        err_range
);

    instr_kind_t w_kind;
    logic [31:0] w_instr;
    logic        w_legal;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [31:0] r_addr;
    logic        r_err_illegal;

    assign w_kind   = instr_kind_t'(in_kind);
    assign w_legal  = (in_kind <= 3'd5);
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && w_legal;
    assign w_pop    = out_valid && out_ready;

    always_comb begin
        w_instr = 32'd0;
        case (w_kind)
            KIND_LW:    w_instr = {in_imm[11:0], in_rs1, c_FUNCT3_WORD, in_rd, LW};
            KIND_SW:    w_instr = {in_imm[11:5], in_rs2, in_rs1, c_FUNCT3_WORD, in_imm[4:0], SW};
            KIND_RTYPE: w_instr = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, RTYPE};
            KIND_BEQ:   w_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, c_FUNCT3_BEQ,
                                   in_imm[4:1], in_imm[11], BEQ};
            KIND_ITYPE: w_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, ITYPE};
            KIND_JAL:   w_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, JAL};
            default:    w_instr = 32'd0;
        endcase
    end

    enc_fifo #(
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_instr),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (out_instr)
    );

    assign in_ready    = !w_full;
    assign out_valid   = !w_empty;
    assign out_addr    = r_addr;
    assign err_illegal = r_err_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr        <= 32'd0;
            r_err_illegal <= 1'b0;
        end else begin
            if (w_pop) begin
                r_addr <= r_addr + 32'd4;
            end
            if (w_accept && !w_legal) begin
                r_err_illegal <= 1'b1;
            end
        end
    end

`ifdef ENC_RANGE_CHECK_EN
    logic w_fits12;
    logic w_fits13;
    logic w_fits21;
    logic w_range_bad;
    logic r_err_range;

    // A value fits an N-bit signed field when bits [31:N-1] are all equal.
    assign w_fits12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
    assign w_fits13 = (&in_imm[31:12]) || !(|in_imm[31:12]);
    assign w_fits21 = (&in_imm[31:20]) || !(|in_imm[31:20]);

    always_comb begin
        w_range_bad = 1'b0;
        case (w_kind)
            KIND_LW, KIND_SW, KIND_ITYPE: w_range_bad = !w_fits12;
            KIND_BEQ:                     w_range_bad = !w_fits13 || in_imm[0];
            KIND_JAL:                     w_range_bad = !w_fits21 || in_imm[0];
            default:                      w_range_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_range <= 1'b0;
        end else if (w_accept && w_range_bad) begin
            r_err_range <= 1'b1;
        end
    end

    assign err_range = r_err_range;
`else
    logic w_unused_imm;

    assign w_unused_imm = ^in_imm[31:21];
    assign err_range    = 1'b0;
`endif

endmodule

`default_nettype wire
